// File: rtl/sram_ctrl_pkg.sv
// Shared types, widths and the byte-merge helper for the Wishbone-to-OpenRAM port controller.
package sram_ctrl_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SPARE_BIT  = 32;
  localparam int unsigned NUM_WMASKS = 4;

  typedef enum logic [2:0] {IDLE, RD, RDW, WR, DONE} state_t;

  // Take selected bytes from new_wd, the rest from old_wd.
  function automatic logic [DATA_W-1:0] byte_merge(input logic [DATA_W-1:0]     old_wd,
                                                   input logic [DATA_W-1:0]     new_wd,
                                                   input logic [NUM_WMASKS-1:0] sel);
    logic [DATA_W-1:0] res;
    for (int i = 0; i < NUM_WMASKS; i++) begin
      res[8*i +: 8] = sel[i] ? new_wd[8*i +: 8] : old_wd[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/sram_wb_parity.sv
// Combinational even-parity generator (32b write data) and checker (33b read word).
module sram_wb_parity
  import sram_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] wdata_i,
  output logic              wpar_o,
  input  logic [DATA_W:0]   rdata_i,
  output logic              rerr_o
);

  assign wpar_o = ^wdata_i;
  assign rerr_o = ^rdata_i;

endmodule

// File: rtl/sram_wb_port_ctrl.sv
// Wishbone classic slave driving one 1RW OpenRAM port; all outputs registered.
// Define SRAM_PARITY_EN to store even parity in the spare bit (partial writes become RMW).
module sram_wb_port_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK  = 32'hFFFF_F800
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_n,
  input  logic                  wbs_cyc_i,
  input  logic                  wbs_stb_i,
  input  logic                  wbs_we_i,
  input  logic [3:0]            wbs_sel_i,
  input  logic [31:0]           wbs_adr_i,
  input  logic [31:0]           wbs_dat_i,
  output logic                  wbs_ack_o,
  output logic [31:0]           wbs_dat_o,
  output logic                  sram_csb0,
  output logic                  sram_web0,
  output logic [3:0]            sram_wmask0,
  output logic                  sram_spare_wen0,
  output logic [ADDR_WIDTH-1:0] sram_addr0,
  output logic [32:0]           sram_din0,
  input  logic [32:0]           sram_dout0,
  output logic                  parity_err_o,
  output logic                  busy_o
);

  localparam logic [NUM_WMASKS-1:0] FullMask = '1;

  state_t                  state_q, state_d;
  logic                    rmw_q, rmw_d;
  logic [NUM_WMASKS-1:0]   sel_q, sel_d;
  logic [DATA_W-1:0]       wdat_q, wdat_d;

  logic                    csb_d, web_d, spare_wen_d, ack_d, perr_d, busy_d;
  logic [NUM_WMASKS-1:0]   wmask_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_W:0]         din_d;
  logic [DATA_W-1:0]       dat_d;

  logic                    req, needs_rmw, wpar, rerr;
  logic [ADDR_WIDTH-1:0]   word_addr;
  logic [DATA_W-1:0]       merged;

  assign req       = wbs_cyc_i & wbs_stb_i & ((wbs_adr_i & ADDR_MASK) == BASE_ADDR);
  assign word_addr = wbs_adr_i[ADDR_WIDTH+1:2];
  assign merged    = byte_merge(sram_dout0[DATA_W-1:0], wdat_q, sel_q);

`ifdef SRAM_PARITY_EN
  localparam bit ParityEn = 1'b1;
  logic [DATA_W-1:0] par_data;
  // The RMW write phase needs parity of the merged word, the direct write of the bus data.
  assign par_data = (state_q == RDW) ? merged : wbs_dat_i;
  sram_wb_parity u_parity (
    .wdata_i (par_data),
    .wpar_o  (wpar),
    .rdata_i (sram_dout0),
    .rerr_o  (rerr)
  );
`else
  localparam bit ParityEn = 1'b0;
  logic unused_spare;
  assign unused_spare = sram_dout0[SPARE_BIT];
  assign wpar = 1'b0;
  assign rerr = 1'b0;
`endif

  assign needs_rmw = ParityEn && (wbs_sel_i != FullMask) && (wbs_sel_i != '0);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state_q         <= IDLE;
      rmw_q           <= 1'b0;
      sel_q           <= '0;
      wdat_q          <= '0;
      sram_csb0       <= 1'b1;
      sram_web0       <= 1'b1;
      sram_wmask0     <= '0;
      sram_spare_wen0 <= 1'b0;
      sram_addr0      <= '0;
      sram_din0       <= '0;
      wbs_ack_o       <= 1'b0;
      wbs_dat_o       <= '0;
      parity_err_o    <= 1'b0;
      busy_o          <= 1'b0;
    end else begin
      state_q         <= state_d;
      rmw_q           <= rmw_d;
      sel_q           <= sel_d;
      wdat_q          <= wdat_d;
      sram_csb0       <= csb_d;
      sram_web0       <= web_d;
      sram_wmask0     <= wmask_d;
      sram_spare_wen0 <= spare_wen_d;
      sram_addr0      <= addr_d;
      sram_din0       <= din_d;
      wbs_ack_o       <= ack_d;
      wbs_dat_o       <= dat_d;
      parity_err_o    <= perr_d;
      busy_o          <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (wbs_we_i && (wbs_sel_i == '0)) state_d = DONE;
          else if (wbs_we_i && !needs_rmw)   state_d = WR;
          else                               state_d = RD;
        end
      end
      RD:      state_d = RDW;
      RDW:     state_d = rmw_q ? WR : DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rmw_d       = rmw_q;
    sel_d       = sel_q;
    wdat_d      = wdat_q;
    csb_d       = sram_csb0;
    web_d       = sram_web0;
    wmask_d     = sram_wmask0;
    spare_wen_d = sram_spare_wen0;
    addr_d      = sram_addr0;
    din_d       = sram_din0;
    dat_d       = wbs_dat_o;
    ack_d       = 1'b0;
    perr_d      = 1'b0;
    busy_d      = (state_d != IDLE);
    unique case (state_q)
      IDLE: begin
        if (req) begin
          rmw_d  = wbs_we_i && needs_rmw;
          sel_d  = wbs_sel_i;
          wdat_d = wbs_dat_i;
          if (wbs_we_i && (wbs_sel_i == '0)) begin
            ack_d = 1'b1;
          end else if (wbs_we_i && !needs_rmw) begin
            csb_d       = 1'b0;
            web_d       = 1'b0;
            wmask_d     = ParityEn ? FullMask : wbs_sel_i;
            spare_wen_d = ParityEn;
            addr_d      = word_addr;
            din_d       = {wpar, wbs_dat_i};
          end else begin
            csb_d  = 1'b0;
            web_d  = 1'b1;
            addr_d = word_addr;
          end
        end
      end
      RD: csb_d = 1'b1;
      RDW: begin
        // dout0 is only valid at this edge; capture or merge it now.
        perr_d = rerr;
        if (rmw_q) begin
          csb_d       = 1'b0;
          web_d       = 1'b0;
          wmask_d     = FullMask;
          spare_wen_d = ParityEn;
          din_d       = {wpar, merged};
        end else begin
          dat_d = sram_dout0[DATA_W-1:0];
          ack_d = 1'b1;
        end
      end
      WR: begin
        csb_d       = 1'b1;
        web_d       = 1'b1;
        wmask_d     = '0;
        spare_wen_d = 1'b0;
        ack_d       = 1'b1;
      end
      DONE:    ack_d = 1'b0;
      default: ;
    endcase
  end

endmodule
